// File: rtl/command_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// command_sequencer_pkg
// Shared definitions for the UART command sequencer:
//   - command byte codes recognised in IDLE
//   - register-file addresses that hold the ALU operands
//   - sequencer state enumeration
//   - response length encoding used by the response serializer
//   - helper that tells whether an incoming byte is discarded in a state
// -----------------------------------------------------------------------------
package command_sequencer_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH         = 8;
    localparam int unsigned DEFAULT_RF_DEPTH           = 16;
    localparam int unsigned DEFAULT_ALU_FUNCTION_WIDTH = 4;

    // Command codes (first byte of every frame)
    localparam int unsigned CMD_WIDTH = 8;
    localparam logic [CMD_WIDTH-1:0] CMD_RF_WRITE        = 8'hAA;
    localparam logic [CMD_WIDTH-1:0] CMD_RF_READ         = 8'hBB;
    localparam logic [CMD_WIDTH-1:0] CMD_ALU_OPERANDS    = 8'hCC;
    localparam logic [CMD_WIDTH-1:0] CMD_ALU_NO_OPERANDS = 8'hDD;

    // Register-file entries that feed the ALU operand inputs
    localparam int unsigned OPERAND_A_ADDR = 0;
    localparam int unsigned OPERAND_B_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        WR_ADDR   = 4'd1,
        WR_DATA   = 4'd2,
        RD_ADDR   = 4'd3,
        RD_WAIT   = 4'd4,
        OP_A      = 4'd5,
        OP_B      = 4'd6,
        ALU_FUNC  = 4'd7,
        ALU_START = 4'd8,
        ALU_WAIT  = 4'd9,
        SEND_0    = 4'd10,
        SEND_1    = 4'd11
    } state_e;

    typedef enum logic {
        RESP_ONE_BYTE  = 1'b0,
        RESP_TWO_BYTES = 1'b1
    } resp_len_e;

    // States that are busy with the datapath or transmitter and have no
    // room for another received byte
    function automatic logic discards_rx(input state_e state);
        return state inside {RD_WAIT, ALU_START, ALU_WAIT, SEND_0, SEND_1};
    endfunction

endpackage

// File: rtl/command_sequencer_response_serializer.sv
// -----------------------------------------------------------------------------
// command_sequencer_response_serializer
// Two-byte response buffer feeding the UART transmitter over a valid/ready
// byte handshake. A load presents the low byte first; when the stored length
// is two bytes the high byte follows after the first transfer.
//
// Ports:
//   reference_clk, reset  clock and asynchronous active-low reset
//   load                  capture load_data/load_length and start sending
//   load_data             response word, low byte sent first
//   load_length           one or two bytes to send
//   tx_ready              transmitter accepts tx_data this cycle
//   tx_data, tx_valid     registered byte handshake towards the transmitter
//   accept_c              a byte transfers this cycle
//   last_c                the byte currently offered is the final one
// -----------------------------------------------------------------------------
module command_sequencer_response_serializer
    import command_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                      reference_clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [2*DATA_WIDTH-1:0]   load_data,
    input  resp_len_e                 load_length,
    input  logic                      tx_ready,
    output logic [DATA_WIDTH-1:0]     tx_data,
    output logic                      tx_valid,
    output logic                      accept_c,
    output logic                      last_c
);

    logic [DATA_WIDTH-1:0] high_byte_q;
    resp_len_e             pending_q;   // high byte still queued behind tx_data

    assign accept_c = tx_valid && tx_ready;
    assign last_c   = (pending_q == RESP_ONE_BYTE);

    // tx_data only moves on load or after a completed transfer, so it is
    // stable while a byte waits for tx_ready
    always_ff @(posedge reference_clk or negedge reset) begin
        if (!reset) begin
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            high_byte_q <= '0;
            pending_q   <= RESP_ONE_BYTE;
        end else if (load) begin
            tx_valid    <= 1'b1;
            tx_data     <= load_data[DATA_WIDTH-1:0];
            high_byte_q <= load_data[2*DATA_WIDTH-1:DATA_WIDTH];
            pending_q   <= load_length;
        end else if (accept_c) begin
            if (pending_q == RESP_TWO_BYTES) begin
                tx_data   <= high_byte_q;
                pending_q <= RESP_ONE_BYTE;
            end else begin
                tx_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/command_sequencer.sv
// -----------------------------------------------------------------------------
// command_sequencer
// Decodes command frames from the synchronized UART RX byte stream and
// sequences register-file and ALU accesses, returning read data (one byte)
// or ALU results (two bytes, low first) to the UART transmitter.
//
// Frames:  AA addr data      register write
//          BB addr           register read, one response byte
//          CC a b func       write operands to entries A/B, run ALU
//          DD func           run ALU on current operand entries
//
// Ports:
//   reference_clk, reset          clock and asynchronous active-low reset
//   rx_data, rx_valid             received byte, one-cycle valid pulse
//   tx_data, tx_valid, tx_ready   response byte handshake
//   rf_address, rf_write_enable, rf_write_data, rf_read_enable
//                                 register-file request strobes
//   rf_read_data, rf_read_data_valid
//                                 register-file read return
//   alu_function, alu_enable      ALU operation code and start strobe
//   alu_result, alu_result_valid  ALU result return
//   alu_clock_enable              ALU clock-gate enable
//   frame_dropped                 one-cycle pulse per discarded byte
// -----------------------------------------------------------------------------
module command_sequencer
    import command_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH          = DEFAULT_DATA_WIDTH,
    parameter int unsigned REGISTER_FILE_DEPTH = DEFAULT_RF_DEPTH,
    parameter int unsigned ADDRESS_WIDTH       = $clog2(REGISTER_FILE_DEPTH),
    parameter int unsigned ALU_FUNCTION_WIDTH  = DEFAULT_ALU_FUNCTION_WIDTH,
    parameter int unsigned OPERAND_A_ADDRESS   = OPERAND_A_ADDR,
    parameter int unsigned OPERAND_B_ADDRESS   = OPERAND_B_ADDR
) (
    input  logic                          reference_clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         rx_data,
    input  logic                          rx_valid,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [ADDRESS_WIDTH-1:0]      rf_address,
    output logic                          rf_write_enable,
    output logic [DATA_WIDTH-1:0]         rf_write_data,
    output logic                          rf_read_enable,
    input  logic [DATA_WIDTH-1:0]         rf_read_data,
    input  logic                          rf_read_data_valid,
    output logic [ALU_FUNCTION_WIDTH-1:0] alu_function,
    output logic                          alu_enable,
    input  logic [2*DATA_WIDTH-1:0]       alu_result,
    input  logic                          alu_result_valid,
    output logic                          alu_clock_enable,
    output logic                          frame_dropped
);

    state_e state_q;
    state_e state_d;

    logic [ADDRESS_WIDTH-1:0]      rf_address_d;
    logic                          rf_write_enable_d;
    logic [DATA_WIDTH-1:0]         rf_write_data_d;
    logic                          rf_read_enable_d;
    logic [ALU_FUNCTION_WIDTH-1:0] alu_function_d;
    logic                          alu_enable_d;
    logic                          alu_clock_enable_d;
    logic                          frame_dropped_d;

    logic                    load_c;
    logic [2*DATA_WIDTH-1:0] load_data_c;
    resp_len_e               load_length_c;
    logic                    accept_c;
    logic                    last_c;

    // Response buffer and transmit handshake
    command_sequencer_response_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_response_serializer (
        .reference_clk (reference_clk),
        .reset         (reset),
        .load          (load_c),
        .load_data     (load_data_c),
        .load_length   (load_length_c),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .accept_c      (accept_c),
        .last_c        (last_c)
    );

    // State and registered outputs
    always_ff @(posedge reference_clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            rf_address       <= '0;
            rf_write_enable  <= 1'b0;
            rf_write_data    <= '0;
            rf_read_enable   <= 1'b0;
            alu_function     <= '0;
            alu_enable       <= 1'b0;
            alu_clock_enable <= 1'b0;
            frame_dropped    <= 1'b0;
        end else begin
            state_q          <= state_d;
            rf_address       <= rf_address_d;
            rf_write_enable  <= rf_write_enable_d;
            rf_write_data    <= rf_write_data_d;
            rf_read_enable   <= rf_read_enable_d;
            alu_function     <= alu_function_d;
            alu_enable       <= alu_enable_d;
            alu_clock_enable <= alu_clock_enable_d;
            frame_dropped    <= frame_dropped_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d            = state_q;
        rf_address_d       = rf_address;
        rf_write_enable_d  = 1'b0;
        rf_write_data_d    = rf_write_data;
        rf_read_enable_d   = 1'b0;
        alu_function_d     = alu_function;
        alu_enable_d       = 1'b0;
        alu_clock_enable_d = alu_clock_enable;
        frame_dropped_d    = 1'b0;
        load_c             = 1'b0;
        load_data_c        = '0;
        load_length_c      = RESP_ONE_BYTE;

        // No buffering: a byte arriving while busy is lost
        if (rx_valid && discards_rx(state_q)) begin
            frame_dropped_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == DATA_WIDTH'(CMD_RF_WRITE)) begin
                        state_d = WR_ADDR;
                    end else if (rx_data == DATA_WIDTH'(CMD_RF_READ)) begin
                        state_d = RD_ADDR;
                    end else if (rx_data == DATA_WIDTH'(CMD_ALU_OPERANDS)) begin
                        state_d = OP_A;
                    end else if (rx_data == DATA_WIDTH'(CMD_ALU_NO_OPERANDS)) begin
                        state_d = ALU_FUNC;
                    end else begin
                        frame_dropped_d = 1'b1;
                    end
                end
            end

            WR_ADDR: begin
                if (rx_valid) begin
                    rf_address_d = rx_data[ADDRESS_WIDTH-1:0];
                    state_d      = WR_DATA;
                end
            end

            WR_DATA: begin
                if (rx_valid) begin
                    rf_write_enable_d = 1'b1;
                    rf_write_data_d   = rx_data;
                    state_d           = IDLE;
                end
            end

            RD_ADDR: begin
                if (rx_valid) begin
                    rf_address_d     = rx_data[ADDRESS_WIDTH-1:0];
                    rf_read_enable_d = 1'b1;
                    state_d          = RD_WAIT;
                end
            end

            RD_WAIT: begin
                if (rf_read_data_valid) begin
                    load_c        = 1'b1;
                    load_data_c   = {{DATA_WIDTH{1'b0}}, rf_read_data};
                    load_length_c = RESP_ONE_BYTE;
                    state_d       = SEND_0;
                end
            end

            OP_A: begin
                if (rx_valid) begin
                    rf_address_d      = ADDRESS_WIDTH'(OPERAND_A_ADDRESS);
                    rf_write_enable_d = 1'b1;
                    rf_write_data_d   = rx_data;
                    state_d           = OP_B;
                end
            end

            OP_B: begin
                if (rx_valid) begin
                    rf_address_d      = ADDRESS_WIDTH'(OPERAND_B_ADDRESS);
                    rf_write_enable_d = 1'b1;
                    rf_write_data_d   = rx_data;
                    state_d           = ALU_FUNC;
                end
            end

            ALU_FUNC: begin
                if (rx_valid) begin
                    alu_function_d     = rx_data[ALU_FUNCTION_WIDTH-1:0];
                    alu_clock_enable_d = 1'b1;
                    state_d            = ALU_START;
                end
            end

            // One cycle of enabled clock before the start strobe
            ALU_START: begin
                alu_enable_d = 1'b1;
                state_d      = ALU_WAIT;
            end

            ALU_WAIT: begin
                if (alu_result_valid) begin
                    load_c             = 1'b1;
                    load_data_c        = alu_result;
                    load_length_c      = RESP_TWO_BYTES;
                    alu_clock_enable_d = 1'b0;
                    state_d            = SEND_0;
                end
            end

            SEND_0: begin
                if (accept_c) begin
                    state_d = last_c ? IDLE : SEND_1;
                end
            end

            SEND_1: begin
                if (accept_c) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_command_sequencer.sv
// -----------------------------------------------------------------------------
// tb_command_sequencer
// Self-checking bench for command_sequencer. The bench plays the register
// file, the ALU and the UART transmitter; expected responses come from a
// bench-side register-file image updated frame by frame and a small ALU
// function. Directed frames are followed by a randomized frame mix.
// -----------------------------------------------------------------------------
module tb_command_sequencer;

    logic        reference_clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  rf_address;
    logic        rf_write_enable;
    logic [7:0]  rf_write_data;
    logic        rf_read_enable;
    logic [7:0]  rf_read_data = 8'h00;
    logic        rf_read_data_valid = 1'b0;
    logic [3:0]  alu_function;
    logic        alu_enable;
    logic [15:0] alu_result = 16'h0000;
    logic        alu_result_valid = 1'b0;
    logic        alu_clock_enable;
    logic        frame_dropped;

    command_sequencer dut (
        .reference_clk      (reference_clk),
        .reset              (reset),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .rf_address         (rf_address),
        .rf_write_enable    (rf_write_enable),
        .rf_write_data      (rf_write_data),
        .rf_read_enable     (rf_read_enable),
        .rf_read_data       (rf_read_data),
        .rf_read_data_valid (rf_read_data_valid),
        .alu_function       (alu_function),
        .alu_enable         (alu_enable),
        .alu_result         (alu_result),
        .alu_result_valid   (alu_result_valid),
        .alu_clock_enable   (alu_clock_enable),
        .frame_dropped      (frame_dropped)
    );

    always #5 reference_clk = ~reference_clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] ref_mem [16];   // expected register-file contents
    logic [7:0] env_rf  [16];   // contents as actually written by the DUT
    logic [7:0] tx_q [$];       // bytes accepted by the transmitter

    int cnt_we = 0, cnt_re = 0, cnt_alu = 0, cnt_drop = 0;
    int multi_strobe = 0, unstable = 0;
    int cke_age = 0, en_age = 0;
    int rd_delay = 0, alu_delay = 0;
    logic [3:0]  last_wr_addr = 4'h0;
    logic [7:0]  last_wr_data = 8'h00;
    logic [3:0]  rd_addr = 4'h0;
    logic [15:0] alu_pending = 16'h0000;
    logic        alu_hold = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_tx = 8'h00;

    // Bench ALU: the operation the environment performs for a function code
    function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [7:0] a,
                                            input logic [7:0] b);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) * 16'(b);
            4'd2:    return 16'(a) - 16'(b);
            4'd3:    return {8'h00, a & b};
            default: return {a, b};
        endcase
    endfunction

    function automatic logic [7:0] q_at(input int i);
        if (i < tx_q.size()) return tx_q[i];
        return 8'hxx;
    endfunction

    // Environment: register file, ALU and transmit monitor, all at negedge
    always @(negedge reference_clk) begin
        rf_read_data_valid = 1'b0;
        alu_result_valid   = 1'b0;
        if (rf_write_enable) begin
            env_rf[rf_address] = rf_write_data;
            cnt_we++;
            last_wr_addr = rf_address;
            last_wr_data = rf_write_data;
        end
        if (rf_read_enable) begin
            cnt_re++;
            rd_addr  = rf_address;
            rd_delay = 2;
        end else if (rd_delay > 0) begin
            rd_delay--;
            if (rd_delay == 0) begin
                rf_read_data       = env_rf[rd_addr];
                rf_read_data_valid = 1'b1;
            end
        end
        cke_age = alu_clock_enable ? cke_age + 1 : 0;
        if (alu_enable) begin
            cnt_alu++;
            en_age = cke_age;
            if (!alu_hold) begin
                alu_delay   = int'($urandom_range(1, 3));
                alu_pending = alu_ref(alu_function, env_rf[0], env_rf[1]);
            end
        end else if (alu_delay > 0) begin
            alu_delay--;
            if (alu_delay == 0) begin
                alu_result       = alu_pending;
                alu_result_valid = 1'b1;
            end
        end
        if (frame_dropped) cnt_drop++;
        if (int'(rf_write_enable) + int'(rf_read_enable) + int'(alu_enable) > 1) multi_strobe++;
        if (prev_stall && tx_valid && (tx_data !== prev_tx)) unstable++;
        prev_stall = tx_valid && !tx_ready;
        prev_tx    = tx_data;
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (!reset) begin
            rd_delay  = 0;
            alu_delay = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge reference_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        repeat ($urandom_range(0, 1)) step();
    endtask

    task automatic wait_tx(input int n, input string tag);
        int budget;
        budget = 300;
        while (tx_q.size() < n && budget > 0) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            step();
            budget--;
        end
        tx_ready = 1'b1;
        check(tag, 32'(tx_q.size()), 32'(n));
    endtask

    task automatic wait_tx_valid(input string tag);
        int budget;
        budget = 50;
        while (!tx_valid && budget > 0) begin
            step();
            budget--;
        end
        check(tag, 32'(tx_valid), 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_strobes"}, 32'({tx_valid, rf_write_enable, rf_read_enable, alu_enable,
                                      alu_clock_enable, frame_dropped}), 32'd0);
        check({tag, "_buses"}, 32'({tx_data, rf_address, rf_write_data, alu_function}), 32'd0);
    endtask

    task automatic do_write(input logic [7:0] abyte, input logic [7:0] data);
        int we0;
        we0 = cnt_we;
        send_byte(8'hAA);
        send_byte(abyte);
        send_byte(data);
        step();
        ref_mem[abyte[3:0]] = data;
        check("wr_strobes", 32'(cnt_we - we0), 32'd1);
        check("wr_addr", 32'(last_wr_addr), 32'(abyte[3:0]));
        check("wr_data", 32'(last_wr_data), 32'(data));
        check("wr_no_tx", 32'(tx_q.size() + int'(tx_valid)), 32'd0);
    endtask

    task automatic do_read(input logic [7:0] abyte, input int stall);
        int re0;
        logic [7:0] exp;
        re0 = cnt_re;
        exp = ref_mem[abyte[3:0]];
        tx_ready = 1'b0;
        send_byte(8'hBB);
        send_byte(abyte);
        wait_tx_valid("rd_response_timeout");
        repeat (stall) step();
        check("rd_hold_valid", 32'(tx_valid), 32'd1);
        check("rd_hold_data", 32'(tx_data), 32'(exp));
        wait_tx(1, "rd_tx_timeout");
        check("rd_byte", 32'(q_at(0)), 32'(exp));
        check("rd_strobes", 32'(cnt_re - re0), 32'd1);
        check("rd_back_idle", 32'(tx_valid), 32'd0);
        tx_q.delete();
    endtask

    task automatic check_alu_response(input logic [15:0] exp, input int alu0);
        check("alu_lo", 32'(q_at(0)), 32'(exp[7:0]));
        check("alu_hi", 32'(q_at(1)), 32'(exp[15:8]));
        check("alu_starts", 32'(cnt_alu - alu0), 32'd1);
        check("alu_cke_lead", 32'(en_age), 32'd2);
        check("alu_cke_off", 32'(alu_clock_enable), 32'd0);
        check("alu_back_idle", 32'(tx_valid), 32'd0);
        tx_q.delete();
    endtask

    task automatic do_alu_ops(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
        int we0, alu0;
        logic [15:0] exp;
        we0  = cnt_we;
        alu0 = cnt_alu;
        ref_mem[0] = a;
        ref_mem[1] = b;
        exp = alu_ref(f[3:0], a, b);
        send_byte(8'hCC);
        send_byte(a);
        send_byte(b);
        send_byte(f);
        wait_tx(2, "alu_ops_tx_timeout");
        check("alu_ops_writes", 32'(cnt_we - we0), 32'd2);
        check("alu_ops_opa", 32'(env_rf[0]), 32'(a));
        check("alu_ops_opb", 32'(env_rf[1]), 32'(b));
        check_alu_response(exp, alu0);
    endtask

    task automatic do_alu(input logic [7:0] f);
        int we0, alu0;
        logic [15:0] exp;
        we0  = cnt_we;
        alu0 = cnt_alu;
        exp  = alu_ref(f[3:0], ref_mem[0], ref_mem[1]);
        send_byte(8'hDD);
        send_byte(f);
        wait_tx(2, "alu_tx_timeout");
        check("alu_no_writes", 32'(cnt_we - we0), 32'd0);
        check_alu_response(exp, alu0);
    endtask

    task automatic do_junk(input logic [7:0] b);
        int d0, s0;
        d0 = cnt_drop;
        s0 = cnt_we + cnt_re + cnt_alu;
        send_byte(b);
        step();
        check("junk_dropped", 32'(cnt_drop - d0), 32'd1);
        check("junk_no_strobe", 32'(cnt_we + cnt_re + cnt_alu - s0), 32'd0);
    endtask

    initial begin
        int d0, a0, budget;
        logic [15:0] exp;
        logic [7:0] b;

        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 8'h00;
            env_rf[i]  = 8'h00;
        end
        reset    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;

        repeat (3) @(posedge reference_clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b1;
        step();
        step();

        // Directed frames
        do_write(8'h05, 8'h3C);
        do_read(8'h05, 10);
        do_alu_ops(8'h0A, 8'h14, 8'h00);
        do_alu(8'h02);
        do_junk(8'h55);

        // Byte arriving while the first response byte waits is dropped
        exp = alu_ref(4'd0, ref_mem[0], ref_mem[1]);
        tx_ready = 1'b0;
        a0 = cnt_alu;
        send_byte(8'hDD);
        send_byte(8'h00);
        wait_tx_valid("send0_timeout");
        d0 = cnt_drop;
        send_byte(8'h77);
        step();
        check("send0_dropped", 32'(cnt_drop - d0), 32'd1);
        check("send0_data_kept", 32'(tx_data), 32'(exp[7:0]));
        wait_tx(2, "send0_tx_timeout");
        check_alu_response(exp, a0);

        // Randomized frame mix
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 4))
                0: do_write(8'($urandom), 8'($urandom));
                1: do_read(8'($urandom), int'($urandom_range(0, 3)));
                2: do_alu_ops(8'($urandom), 8'($urandom), 8'($urandom));
                3: do_alu(8'($urandom));
                default: begin
                    b = 8'($urandom);
                    while (b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) b = 8'($urandom);
                    do_junk(b);
                end
            endcase
        end

        // Asynchronous reset while waiting on the ALU
        alu_hold = 1'b1;
        a0 = cnt_alu;
        send_byte(8'hDD);
        send_byte(8'h03);
        budget = 50;
        while (cnt_alu == a0 && budget > 0) begin
            step();
            budget--;
        end
        check("rst_alu_started", 32'(cnt_alu - a0), 32'd1);
        check("rst_pre_cke", 32'(alu_clock_enable), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_outputs_zero("rst_async");
        step();
        reset    = 1'b1;
        alu_hold = 1'b0;
        step();
        do_write(8'h39, 8'hA5);
        do_read(8'h09, 1);

        check("multi_strobe", 32'(multi_strobe), 32'd0);
        check("tx_unstable", 32'(unstable), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
